// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// seg7_scan_driver : four-digit multiplexed common-anode 7-segment scanner
// Revision: 1.0
// ============================================================================
module seg7_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk100MHz,
    input  logic       rst,
    input  logic [3:0] tenmin,
    input  logic [3:0] onemin,
    input  logic [3:0] tensec,
    input  logic [3:0] onesec,
    input  logic       blank_lead,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int            PW        = $clog2(SCAN_DIV);
    localparam int            FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]      pre_q, pre_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0][3:0]    snap_q, snap_d;
    logic [FW-1:0]      fcnt_q, fcnt_d;
    logic               phase_q, phase_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               tick_q, tick_d;

    logic               step, bnd, dark, lz;
    logic [3:0]         digit;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        step   = (pre_q == PRE_LAST);
        bnd    = step && (idx_q == 2'd3);
        pre_d  = step ? '0 : pre_q + 1'b1;
        idx_d  = step ? idx_q + 2'd1 : idx_q;
        snap_d = bnd ? {tenmin, onemin, tensec, onesec} : snap_q;

        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (!blink_en) begin
            fcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bnd) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        // Next-state snapshot and phase are used so a boundary takes effect in slot 0
        dark  = blink_en && phase_d;
        lz    = blank_lead && (snap_d[3] == 4'd0) && (idx_d == 2'd3);
        digit = snap_d[idx_d];

        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (step) begin
            an_d  = (dark || lz) ? 4'b1111 : ~(4'b0001 << idx_d);
            seg_d = seg_of(digit);
            dp_d  = dark || (idx_d != 2'd2);
        end
        tick_d = bnd;
    end

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            pre_q   <= '0;
            idx_q   <= 2'd3;
            snap_q  <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// tb_seg7_scan_driver : directed bench with a slot-arithmetic reference model
// Revision: 1.0
// ============================================================================
module tb_seg7_scan_driver;

    localparam int SD = 4;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tenmin, onemin, tensec, onesec;
    logic       blank_lead, blink_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame_tick;

    int checks   = 0;
    int failures = 0;

    seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk100MHz (clk),
        .rst       (rst),
        .tenmin    (tenmin),
        .onemin    (onemin),
        .tensec    (tensec),
        .onesec    (onesec),
        .blank_lead(blank_lead),
        .blink_en  (blink_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (d < 4'd10) ? tbl[d] : 7'b0111111;
    endfunction

    // Reference: n counts cycles since reset release; step k happens at n = k*SD + SD-1
    // and selects slot k mod 4, with slot 0 steps being frame boundaries.
    int         n, bf, bf_nx, m_slot;
    logic       m_step, m_bnd, m_dark, m_blank;
    logic [3:0] m_snap [4];
    logic [3:0] snap_nx [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp, exp_tick;

    always_comb begin
        m_step  = (n % SD) == SD - 1;
        m_slot  = (n / SD) % 4;
        m_bnd   = m_step && (m_slot == 0);
        snap_nx = m_snap;
        if (m_bnd) snap_nx = '{onesec, tensec, onemin, tenmin};
        bf_nx   = !blink_en ? 0 : (m_bnd ? bf + 1 : bf);
        m_dark  = blink_en && (((bf_nx / BF) % 2) == 1);
        m_blank = blank_lead && (snap_nx[3] == 4'd0);
    end

    always @(posedge clk) begin
        if (rst) begin
            n        <= 0;
            bf       <= 0;
            m_snap   <= '{4'd0, 4'd0, 4'd0, 4'd0};
            exp_an   <= 4'b1111;
            exp_seg  <= 7'b1111111;
            exp_dp   <= 1'b1;
            exp_tick <= 1'b0;
        end else begin
            n        <= n + 1;
            bf       <= bf_nx;
            m_snap   <= snap_nx;
            exp_tick <= m_bnd;
            if (m_step) begin
                exp_an  <= (m_dark || (m_slot == 3 && m_blank)) ? 4'b1111 : ~(4'b0001 << m_slot);
                exp_seg <= ref_seg(snap_nx[m_slot]);
                exp_dp  <= m_dark || (m_slot != 2);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    // Every cycle passes through here, so the model comparison sees each one.
    task automatic step_cyc();
        @(negedge clk);
        chk("model_an",   32'(an),         32'(exp_an));
        chk("model_seg",  32'(seg),        32'(exp_seg));
        chk("model_dp",   32'(dp),         32'(exp_dp));
        chk("model_tick", 32'(frame_tick), 32'(exp_tick));
    endtask

    task automatic next_slot();
        repeat (SD) step_cyc();
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 8 * SD; i++) begin
            step_cyc();
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
        end
        chk("tick_timeout", 32'(seen), 32'd1);
    endtask

    task automatic chk_slot(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        chk({name, "_an"},  32'(an),  32'(ea));
        chk({name, "_seg"}, 32'(seg), 32'(es));
        chk({name, "_dp"},  32'(dp),  32'(ed));
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        {tenmin, onemin, tensec, onesec} = {4'd1, 4'd2, 4'd3, 4'd4};
        blank_lead = 1'b0;
        blink_en   = 1'b0;

        // Reset state and first frame latency
        repeat (3) step_cyc();
        chk_slot("reset", 4'b1111, 7'b1111111, 1'b1);
        chk("reset_tick", 32'(frame_tick), 32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4 * SD; i++) begin
            step_cyc();
            cnt++;
            if (frame_tick) break;
        end
        chk("first_tick_latency", 32'(cnt), 32'(SD));

        // Scan order and decode, with a mid-frame input change
        chk_slot("s0", 4'b1110, 7'b0011001, 1'b1);
        next_slot();
        chk_slot("s1", 4'b1101, 7'b0110000, 1'b1);
        onesec = 4'd7;
        next_slot();
        chk_slot("s2", 4'b1011, 7'b0100100, 1'b0);
        next_slot();
        chk_slot("s3", 4'b0111, 7'b1111001, 1'b1);
        next_slot();
        chk("tearfree_tick", 32'(frame_tick), 32'd1);
        chk_slot("tearfree_s0", 4'b1110, 7'b1111000, 1'b1);

        // Leading-zero blanking and out-of-range code
        tenmin = 4'd0;
        blank_lead = 1'b1;
        tensec = 4'hC;
        wait_tick();
        chk_slot("lz_s0", 4'b1110, 7'b1111000, 1'b1);
        next_slot();
        chk_slot("dash_s1", 4'b1101, 7'b0111111, 1'b1);
        next_slot();
        next_slot();
        chk_slot("lz_s3", 4'b1111, 7'b1000000, 1'b1);
        blank_lead = 1'b0;
        wait_tick();
        repeat (3) next_slot();
        chk_slot("nolz_s3", 4'b0111, 7'b1000000, 1'b1);

        // Blink: one normal frame, two dark, then normal again
        blink_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_tick();
            if (f == 1 || f == 2) begin
                chk("blink_dark_s0", 32'(an), 32'(4'b1111));
                next_slot();
                next_slot();
                chk("blink_dark_dp", 32'(dp), 32'd1);
            end else begin
                chk("blink_lit_s0", 32'(an), 32'(4'b1110));
                next_slot();
                next_slot();
                chk("blink_lit_dp", 32'(dp), 32'd0);
            end
        end
        wait_tick();
        wait_tick();
        chk("blink_dark2_s0", 32'(an), 32'(4'b1111));
        next_slot();
        chk("blink_dark2_s1", 32'(an), 32'(4'b1111));
        blink_en = 1'b0;
        next_slot();
        chk_slot("blink_off_s2", 4'b1011, 7'b0100100, 1'b0);

        // Reset during slot 2 clears the snapshot
        {tenmin, onemin, tensec, onesec} = 16'h0000;
        rst = 1'b1;
        step_cyc();
        chk_slot("midrst", 4'b1111, 7'b1111111, 1'b1);
        chk("midrst_tick", 32'(frame_tick), 32'd0);
        rst = 1'b0;
        wait_tick();
        chk_slot("post_s0", 4'b1110, 7'b1000000, 1'b1);
        next_slot();
        chk_slot("post_s1", 4'b1101, 7'b1000000, 1'b1);
        next_slot();
        chk_slot("post_s2", 4'b1011, 7'b1000000, 1'b0);
        next_slot();
        chk_slot("post_s3", 4'b0111, 7'b1000000, 1'b1);
        step_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
